// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode/sequencer types and constants
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FLUSH = 3'd2,
    ST_SYS   = 3'd3,
    ST_REL   = 3'd4
  } sc_state_e;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000c;

  // Decode compares the ALU code against these to derive no_sys_notify.
  localparam logic [5:0] ALU_LL = 6'b101000;
  localparam logic [5:0] ALU_SC = 6'b110110;

endpackage

// File: rtl/syscall_flush_sequencer.sv
// rtl/syscall_flush_sequencer.sv - holds a SYSCALL/LL/SC in decode through drain, cache flush and SYS notify
module syscall_flush_sequencer
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        syscall_valid,
  input  logic [31:0] syscall_pc,
  input  logic        no_sys_notify,
  input  logic        pipe_stall,
  input  logic        flush_finished,
  output logic        bubble,
  output logic        want_freeze,
  output logic        flush_req,
  output logic        sys_pulse,
  output logic        inhibit_freeze,
  output logic        busy,
  output logic        flush_timeout,
  output logic [2:0]  sys_count
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]      DRAIN_INIT = 3'(DRAIN_CYCLES);
  localparam logic [TW-1:0]   TO_MAX     = TW'(TIMEOUT_CYCLES);

  sc_state_e     state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          pc_done_q, pc_done_d;
  logic          same_pc;
  logic          new_sc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      last_pc_q <= '0;
      pc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      last_pc_q <= last_pc_d;
      pc_done_q <= pc_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_cnt_d       = '0;
    timeout_d      = timeout_q;
    last_pc_d      = last_pc_q;
    bubble         = 1'b0;
    want_freeze    = 1'b0;
    flush_req      = 1'b0;
    sys_pulse      = 1'b0;
    inhibit_freeze = 1'b0;

    // A SYSCALL already released stays done only while it remains in ID at the same PC;
    // RESET gating keeps the combinational IDLE outputs low while reset is held.
    same_pc   = (syscall_pc == last_pc_q);
    new_sc    = syscall_valid & ~RESET & ~(pc_done_q & same_pc);
    pc_done_d = pc_done_q & syscall_valid & same_pc;

    case (state_q)
      ST_IDLE: begin
        bubble      = new_sc;
        want_freeze = new_sc;
        if (new_sc) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        bubble      = 1'b1;
        want_freeze = 1'b1;
        if (!pipe_stall && cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        if (!syscall_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd1 && !pipe_stall) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_req   = 1'b1;
        bubble      = 1'b1;
        want_freeze = 1'b1;
        if (to_cnt_q == TO_MAX) begin
          to_cnt_d  = to_cnt_q;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
        if (flush_finished) begin
          state_d = ST_SYS;
        end
      end
      ST_SYS: begin
        sys_pulse   = ~no_sys_notify;
        bubble      = 1'b1;
        want_freeze = 1'b1;
        state_d     = ST_REL;
      end
      ST_REL: begin
        inhibit_freeze = 1'b1;
        last_pc_d      = syscall_pc;
        pc_done_d      = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign flush_timeout = timeout_q;
  assign sys_count     = cnt_q;

endmodule

// File: tb/tb_syscall_flush_sequencer.sv
// tb/tb_syscall_flush_sequencer.sv - directed vector bench for syscall_flush_sequencer
module tb_syscall_flush_sequencer;

  logic        CLK;
  logic        RESET;
  logic        syscall_valid;
  logic [31:0] syscall_pc;
  logic        no_sys_notify;
  logic        pipe_stall;
  logic        flush_finished;
  logic        bubble;
  logic        want_freeze;
  logic        flush_req;
  logic        sys_pulse;
  logic        inhibit_freeze;
  logic        busy;
  logic        flush_timeout;
  logic [2:0]  sys_count;

  int n_vec  = 0;
  int n_fail = 0;

  syscall_flush_sequencer #(.DRAIN_CYCLES(3), .TIMEOUT_CYCLES(255)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .syscall_valid  (syscall_valid),
    .syscall_pc     (syscall_pc),
    .no_sys_notify  (no_sys_notify),
    .pipe_stall     (pipe_stall),
    .flush_finished (flush_finished),
    .bubble         (bubble),
    .want_freeze    (want_freeze),
    .flush_req      (flush_req),
    .sys_pulse      (sys_pulse),
    .inhibit_freeze (inhibit_freeze),
    .busy           (busy),
    .flush_timeout  (flush_timeout),
    .sys_count      (sys_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {bubble, want_freeze, flush_req, sys_pulse, inhibit_freeze, busy, flush_timeout}
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        nsn;
    logic        stall;
    logic        fin;
    logic [6:0]  e_out;
    logic [3:0]  e_cnt;   // bit 3 set: sys_count not checked
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic nsn, logic stall, logic fin,
                              logic [6:0] e_out, logic [3:0] e_cnt);
    vec_t r;
    r.v = v; r.pc = pc; r.nsn = nsn; r.stall = stall; r.fin = fin;
    r.e_out = e_out; r.e_cnt = e_cnt;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {bubble, want_freeze, flush_req, sys_pulse, inhibit_freeze, busy, flush_timeout};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // syscall at 0x400100, then 0x400104 with stalls, LL at 0x400104, squash at 0x400200
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b1100000, 4'd0));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b1100010, 4'd3));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b1100010, 4'd1));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 1, 7'b1110010, 4'd0));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b1101010, 4'd0));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b0000110, 4'd0));
    tbl.push_back(mk(1, 32'h400100, 0, 0, 0, 7'b0000000, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b1100000, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 1, 7'b1100010, 4'd3));
    tbl.push_back(mk(1, 32'h400104, 0, 1, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(1, 32'h400104, 0, 1, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b1100010, 4'd1));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b1110010, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 1, 7'b1110010, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b1101010, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 0, 0, 0, 7'b0000110, 4'd0));
    tbl.push_back(mk(0, 32'h400104, 0, 0, 0, 7'b0000000, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b1100000, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b1100010, 4'd3));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b1100010, 4'd1));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 1, 7'b1110010, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b1100010, 4'd0));
    tbl.push_back(mk(1, 32'h400104, 1, 0, 0, 7'b0000110, 4'd0));
    tbl.push_back(mk(0, 32'h400104, 0, 0, 0, 7'b0000000, 4'd0));
    tbl.push_back(mk(1, 32'h400200, 0, 0, 0, 7'b1100000, 4'd0));
    tbl.push_back(mk(1, 32'h400200, 0, 0, 0, 7'b1100010, 4'd3));
    tbl.push_back(mk(0, 32'h400200, 0, 0, 0, 7'b1100010, 4'd2));
    tbl.push_back(mk(0, 32'h400200, 0, 0, 0, 7'b0000000, 4'd8));
    tbl.push_back(mk(0, 32'h400200, 0, 0, 1, 7'b0000000, 4'd8));

    RESET = 1'b1;
    syscall_valid = 1'b1;
    syscall_pc = 32'h400100;
    no_sys_notify = 1'b0;
    pipe_stall = 1'b0;
    flush_finished = 1'b0;
    repeat (2) @(posedge CLK);
    #4;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_cnt", 32'(sys_count), 32'd0);
    next_cycle();
    RESET = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      syscall_valid  = tbl[i].v;
      syscall_pc     = tbl[i].pc;
      no_sys_notify  = tbl[i].nsn;
      pipe_stall     = tbl[i].stall;
      flush_finished = tbl[i].fin;
      #3;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].e_out));
      if (!tbl[i].e_cnt[3])
        chk($sformatf("vec%0d_cnt", i), 32'(sys_count), 32'(tbl[i].e_cnt[2:0]));
      next_cycle();
    end

    // flush_finished withheld: timeout goes sticky while the sequence stays in FLUSH
    RESET = 1'b1;
    #3;
    next_cycle();
    RESET = 1'b0;
    syscall_valid = 1'b1;
    syscall_pc = 32'h400300;
    flush_finished = 1'b0;
    repeat (4) next_cycle();
    for (int k = 1; k <= 260; k++) begin
      #3;
      if (k == 1)   chk("to_first_flush", 32'(outs()), 32'b1110010);
      if (k == 254) chk("to_not_yet", 32'(outs()), 32'b1110010);
      if (k == 258) chk("to_set", 32'(outs()), 32'b1110011);
      if (k == 260) chk("to_still_flush", 32'(outs()), 32'b1110011);
      next_cycle();
    end
    flush_finished = 1'b1;
    #3;
    chk("to_finish_cycle", 32'(outs()), 32'b1110011);
    next_cycle();
    flush_finished = 1'b0;
    #3;
    chk("to_sys", 32'(outs()), 32'b1101011);
    next_cycle();
    #3;
    chk("to_rel", 32'(outs()), 32'b0000111);
    next_cycle();
    #3;
    chk("to_idle_sticky", 32'(outs()), 32'b0000001);
    next_cycle();

    // RESET on the second FLUSH cycle
    syscall_pc = 32'h400400;
    #3;
    chk("rst_seq_start", 32'(outs()), 32'b1100001);
    next_cycle();
    repeat (3) next_cycle();
    next_cycle();
    chk("rst_flush2", 32'(outs()), 32'b1110011);
    RESET = 1'b1;
    #1;
    chk("rst_async_outs", 32'(outs()), 32'd0);
    chk("rst_async_cnt", 32'(sys_count), 32'd0);
    next_cycle();
    chk("rst_held", 32'(outs()), 32'd0);
    RESET = 1'b0;
    syscall_valid = 1'b0;
    #3;
    chk("rst_idle", 32'(outs()), 32'd0);
    next_cycle();
    #3;
    chk("rst_stays_idle", 32'(outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
